csa_operand_sequencer: RTL and testbench

//  Streams WIDTH-bit operands in over a valid/ready port, groups them in threes and drives them to the

---
 rtl/csa_seq_pkg.sv | 17 +
 rtl/csa_operand_sequencer.sv | 107 ++++++++++
 tb/tb_csa_operand_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/csa_seq_pkg.sv
// Shared types and sizing helpers for the carry-save operand sequencer.
package csa_seq_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    EVAL = 2'd1,
    OUT  = 2'd2
  } state_t;

  // {cout, sum} from a three-operand add of w-bit values.
  function automatic int res_w(input int w);
    return w + 2;
  endfunction

endpackage

// File: rtl/csa_operand_sequencer.sv
// Groups streamed operands in threes for an external three-operand adder and
// registers the adder's {cout, sum} into a valid/ready result port.
module csa_operand_sequencer
  import csa_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  localparam int RES_W = res_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] op_c,
  input  logic [WIDTH:0]   sum_in,
  input  logic             cout_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_data,
  output logic [1:0]       out_count,
  output logic             out_partial
);

  state_t           state;
  state_t           state_next;
  logic [1:0]       cnt;
  logic [WIDTH-1:0] slot_a;
  logic [WIDTH-1:0] slot_b;
  logic [WIDTH-1:0] slot_c;
  logic             accept;
  logic             fill_done;
  logic             close_group;

  assign in_ready  = (state == FILL) && !rst;
  assign out_valid = (state == OUT);
  assign accept    = in_valid && in_ready;
  assign op_a      = slot_a;
  assign op_b      = slot_b;
  assign op_c      = slot_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    fill_done   = 1'b0;
    close_group = 1'b0;
    case (state)
      FILL: begin
        fill_done   = accept && (cnt == 2'd2);
        // A flush on an empty group only closes it if an operand arrives with it.
        close_group = fill_done || (flush && ((cnt != 2'd0) || accept));
        if (close_group) state_next = EVAL;
      end
      EVAL: state_next = OUT;
      OUT: if (out_ready) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  // Slots are cleared when a result is consumed, so unfilled slots of a
  // flushed group are already zero when the adder sees them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= 2'd0;
      slot_a      <= '0;
      slot_b      <= '0;
      slot_c      <= '0;
      out_data    <= '0;
      out_count   <= 2'd0;
      out_partial <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            case (cnt)
              2'd0:    slot_a <= in_data;
              2'd1:    slot_b <= in_data;
              default: slot_c <= in_data;
            endcase
            cnt <= cnt + 2'd1;
          end
          if (close_group) begin
            out_count   <= cnt + {1'b0, accept};
            out_partial <= !fill_done;
          end
        end
        EVAL: out_data <= {cout_in, sum_in};
        OUT: begin
          if (out_ready) begin
            cnt    <= 2'd0;
            slot_a <= '0;
            slot_b <= '0;
            slot_c <= '0;
          end
        end
        default: cnt <= 2'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_operand_sequencer.sv
// Bench for csa_operand_sequencer with a behavioural three-operand adder beside it.
module tb_csa_operand_sequencer;

  localparam int W  = 4;
  localparam int RW = W + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          flush;
  logic [W-1:0]  op_a, op_b, op_c;
  logic [W:0]    sum_in;
  logic          cout_in;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_data;
  logic [1:0]    out_count;
  logic          out_partial;
  logic [RW-1:0] tot;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign tot     = {2'b00, op_a} + {2'b00, op_b} + {2'b00, op_c};
  assign sum_in  = tot[W:0];
  assign cout_in = tot[W+1];

  csa_operand_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .flush(flush), .op_a(op_a), .op_b(op_b), .op_c(op_c),
    .sum_in(sum_in), .cout_in(cout_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
    .out_partial(out_partial)
  );

  typedef struct {
    logic [W-1:0]  a, b, c;
    int            nops;
    bit            flush_last;
    logic [RW-1:0] data;
    logic [1:0]    cnt;
    logic          part;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pushes the operands of v, closes the group, and leaves the DUT in EVAL.
  task automatic push_group(input vec_t v);
    logic [W-1:0] ops[3];
    ops[0] = v.a; ops[1] = v.b; ops[2] = v.c;
    for (int i = 0; i < v.nops; i++) begin
      in_valid = 1'b1;
      in_data  = ops[i];
      flush    = (i == v.nops - 1) && v.flush_last;
      tick();
    end
    in_valid = 1'b0;
    if (v.nops < 3 && !v.flush_last) begin
      flush = 1'b1;
      tick();
    end
    flush = 1'b0;
  endtask

  task automatic run_vec(input int k, input vec_t v);
    push_group(v);
    check($sformatf("v%0d eval_valid", k), out_valid, 0);
    check($sformatf("v%0d eval_ready", k), in_ready, 0);
    check($sformatf("v%0d op_a", k), op_a, v.a);
    check($sformatf("v%0d op_b", k), op_b, (v.nops > 1) ? v.b : 4'd0);
    check($sformatf("v%0d op_c", k), op_c, (v.nops > 2) ? v.c : 4'd0);
    tick();
    check($sformatf("v%0d out_valid", k), out_valid, 1);
    check($sformatf("v%0d out_data", k), out_data, v.data);
    check($sformatf("v%0d out_count", k), out_count, v.cnt);
    check($sformatf("v%0d out_partial", k), out_partial, v.part);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check($sformatf("v%0d released", k), out_valid, 0);
    check($sformatf("v%0d refill_ready", k), in_ready, 1);
  endtask

  function automatic vec_t mk(input int a, input int b, input int c, input int n,
                              input bit fl, input int d, input int cn, input bit p);
    vec_t v;
    v.a = W'(a); v.b = W'(b); v.c = W'(c); v.nops = n; v.flush_last = fl;
    v.data = RW'(d); v.cnt = 2'(cn); v.part = p;
    return v;
  endfunction

  // Reference model state for the random phase.
  int        acc_q[$];
  logic [RW-1:0] exp_data_q[$];
  int        exp_cnt_q[$];
  bit        exp_part_q[$];
  bit        pending;

  initial begin
    vec_t v;
    int   sum, held;

    vecs[0] = mk(3, 5, 7, 3, 0, 15, 3, 0);
    vecs[1] = mk(15, 15, 15, 3, 0, 45, 3, 0);
    vecs[2] = mk(9, 4, 0, 2, 0, 13, 2, 1);
    vecs[3] = mk(2, 4, 6, 3, 1, 12, 3, 0);
    vecs[4] = mk(1, 0, 0, 1, 1, 1, 1, 1);
    vecs[5] = mk(15, 15, 0, 2, 1, 30, 2, 1);
    vecs[6] = mk(0, 0, 0, 3, 0, 0, 3, 0);

    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check("rst in_ready", in_ready, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    check("rst out_count", out_count, 0);
    check("rst out_partial", out_partial, 0);
    check("rst ops", {op_a, op_b, op_c}, 0);
    rst = 1'b0;
    tick();
    check("post-rst in_ready", in_ready, 1);

    for (int k = 0; k < 7; k++) run_vec(k, vecs[k]);

    // Flush on an empty group is ignored.
    flush = 1'b1;
    tick(); tick();
    flush = 1'b0;
    check("empty flush out_valid", out_valid, 0);
    check("empty flush in_ready", in_ready, 1);
    run_vec(7, mk(1, 2, 3, 3, 0, 6, 3, 0));

    // Backpressure in OUT: result held, operands refused.
    push_group(mk(10, 11, 12, 3, 0, 33, 3, 0));
    tick();
    held = out_data;
    in_valid = 1'b1; in_data = 4'd9;
    for (int i = 0; i < 4; i++) begin
      check("stall out_valid", out_valid, 1);
      check("stall in_ready", in_ready, 0);
      check("stall out_data", out_data, 33);
      tick();
    end
    check("stall held", out_data, held);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    run_vec(8, mk(1, 1, 1, 3, 0, 3, 3, 0));

    // Reset after two accepts drops the partial group.
    in_valid = 1'b1; in_data = 4'd7;
    tick(); tick();
    in_valid = 1'b0; rst = 1'b1;
    #1;
    check("midrst in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    tick();
    run_vec(9, mk(1, 1, 1, 3, 0, 3, 3, 0));

    // Reset while a result is held drops out_valid immediately.
    push_group(mk(5, 5, 5, 3, 0, 15, 3, 0));
    tick();
    check("pre-rst out_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("rst in OUT out_valid", out_valid, 0);
    check("rst in OUT out_data", out_data, 0);
    tick();
    rst = 1'b0;
    tick();

    // Random traffic against a queue-based model.
    pending = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom);
      flush     = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      check("rand in_ready", in_ready, !pending);
      if (out_valid && out_ready) begin
        if (exp_data_q.size() == 0) begin
          check("rand unexpected result", 1, 0);
        end else begin
          check("rand out_data", out_data, exp_data_q.pop_front());
          check("rand out_count", out_count, exp_cnt_q.pop_front());
          check("rand out_partial", out_partial, exp_part_q.pop_front());
          pending = 1'b0;
        end
      end
      if (in_ready) begin
        if (in_valid) acc_q.push_back(int'(in_data));
        if (acc_q.size() == 3 || (flush && acc_q.size() > 0)) begin
          sum = 0;
          foreach (acc_q[i]) sum += acc_q[i];
          exp_data_q.push_back(RW'(sum));
          exp_cnt_q.push_back(acc_q.size());
          exp_part_q.push_back(acc_q.size() != 3);
          acc_q.delete();
          pending = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end

    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_data_q.size() > 0; i++) begin
      if (out_valid) begin
        check("drain out_data", out_data, exp_data_q.pop_front());
        check("drain out_count", out_count, exp_cnt_q.pop_front());
        check("drain out_partial", out_partial, exp_part_q.pop_front());
      end
      tick();
    end
    check("drain empty", exp_data_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
